// File: rtl/i2c_target.sv
// I2C target exposing an 8-bit-addressed register window with an auto-incrementing pointer.
// START/STOP are decoded in every state; bits are sampled on SCL rise and SDA changes only after SCL fall.
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h42
) (
    input  logic       clk_i,
    input  logic       n_reset_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oen_o,
    output logic [7:0] adr_o,
    output logic [7:0] dat_o,
    output logic       wr_o,
    output logic       rd_o,
    input  logic [7:0] dat_i,
    output logic       busy_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_h_q, sda_h_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  dat_q, dat_d;
    logic        sda_oen_q, sda_oen_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        busy_q, busy_d;

    logic        scl_s, sda_s;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  shift_in;
    logic        addr_match;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_h_q;
    assign scl_fall  = ~scl_s & scl_h_q;
    assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
    assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;
    assign shift_in  = {sr_q[6:0], sda_s};
    assign addr_match = (shift_in[7:1] == ADDRESS) && (shift_in[7:1] != 7'd0);

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            ptr_q      <= '0;
            dat_q      <= '0;
            sda_oen_q  <= 1'b1;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_h_q    <= scl_s;
            sda_h_q    <= sda_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ptr_q      <= ptr_d;
            dat_q      <= dat_d;
            sda_oen_q  <= sda_oen_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        dat_d     = dat_q;
        sda_oen_d = sda_oen_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        busy_d    = busy_q;

        if (wr_q) ptr_d = ptr_q + 8'd1;

        if (start_det) begin
            state_d   = S_ADDR;
            cnt_d     = '0;
            sda_oen_d = 1'b1;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            sda_oen_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        sr_d = shift_in;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (state_q == S_PTR) begin
                                state_d = S_PTR_ACK;
                            end else if (state_q == S_WDATA) begin
                                state_d = S_WDATA_ACK;
                            end else if (addr_match) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                // In the ACK states SDA is still released at the first fall and driven at the second,
                // so sda_oen_q itself tells which half of the ACK bit we are in.
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (sda_oen_q) begin
                            sda_oen_d = 1'b0;
                        end else begin
                            sda_oen_d = 1'b1;
                            cnt_d     = '0;
                            if (sr_q[0]) begin
                                state_d = S_RDATA;
                                rd_d    = 1'b1;
                            end else begin
                                state_d = S_PTR;
                            end
                        end
                    end
                end
                S_PTR_ACK: begin
                    if (scl_fall) begin
                        if (sda_oen_q) begin
                            sda_oen_d = 1'b0;
                            ptr_d     = sr_q;
                        end else begin
                            sda_oen_d = 1'b1;
                            state_d   = S_WDATA;
                        end
                    end
                end
                S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (sda_oen_q) begin
                            sda_oen_d = 1'b0;
                            wr_d      = 1'b1;
                            dat_d     = sr_q;
                        end else begin
                            sda_oen_d = 1'b1;
                            state_d   = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (rd_q) begin
                        sr_d      = dat_i;
                        sda_oen_d = dat_i[7];
                        ptr_d     = ptr_q + 8'd1;
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oen_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = S_RDATA_ACK;
                        end else begin
                            sr_d      = {sr_q[6:0], 1'b0};
                            sda_oen_d = sr_q[6];
                        end
                    end
                end
                // cnt_q == 1 records that the controller acknowledged the byte.
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            cnt_d = 4'd1;
                        end else begin
                            state_d = S_WAIT;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d   = '0;
                        rd_d    = 1'b1;
                        state_d = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oen_o = sda_oen_q;
    assign adr_o     = ptr_q;
    assign dat_o     = dat_q;
    assign wr_o      = wr_q;
    assign rd_o      = rd_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bus controller model drives SCL/SDA at 400 kHz against a 50 MHz clock.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int unsigned Q = 625;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_c = 1'b1;
    logic       sda_line;
    logic       sda_oen;
    logic [7:0] adr, dat_o, dat_i;
    logic       wr, rd, busy;
    logic [7:0] rd_mem [256];

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] wr_log [$];
    logic [7:0]  rd_log [$];
    int overlap = 0;
    int wide = 0;
    logic wr_prev = 1'b0, rd_prev = 1'b0;

    assign sda_line = sda_c & sda_oen;
    assign dat_i = rd_mem[adr];

    i2c_target #(.ADDRESS(7'h42)) dut (
        .clk_i(clk), .n_reset_i(n_reset), .scl_i(scl), .sda_i(sda_line),
        .sda_oen_o(sda_oen), .adr_o(adr), .dat_o(dat_o), .wr_o(wr), .rd_o(rd),
        .dat_i(dat_i), .busy_o(busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (wr) wr_log.push_back({adr, dat_o});
        if (rd) rd_log.push_back(adr);
        if (wr && rd) overlap++;
        if ((wr && wr_prev) || (rd && rd_prev)) wide++;
        wr_prev <= wr;
        rd_prev <= rd;
    end

    task automatic i2c_start();
        sda_c = 1'b1; #Q;
        scl = 1'b1;   #Q;
        sda_c = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0; #Q;
        scl = 1'b1;   #Q;
        sda_c = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_c = b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_c = 1'b1; #Q;
        scl = 1'b1;   #Q;
        ack = ~sda_line;
        #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_c = 1'b1; #Q;
            scl = 1'b1;   #Q;
            b[i] = sda_line;
            #Q;
            scl = 1'b0;   #Q;
        end
        sda_c = ~give_ack; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
        sda_c = 1'b1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        #55;
        n_cmp++; if (sda_oen !== 1'b1) begin n_bad++; $display("FAIL reset_sda_oen got %b want 1", sda_oen); end
        n_cmp++; if (wr !== 1'b0 || rd !== 1'b0) begin n_bad++; $display("FAIL reset_strobes got wr=%b rd=%b want 0 0", wr, rd); end
        n_cmp++; if (adr !== 8'h00 || dat_o !== 8'h00) begin n_bad++; $display("FAIL reset_bus got adr=%h dat=%h want 00 00", adr, dat_o); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_reset = 1'b1;
        #200;
    endtask

    task automatic test_write_burst();
        logic a0, a1, a2, a3;
        clear_logs();
        i2c_start();
        write_byte(8'h84, a0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wb_busy got %b want 1", busy); end
        write_byte(8'h10, a1);
        write_byte(8'hAA, a2);
        write_byte(8'h55, a3);
        i2c_stop();
        #200;
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_bad++; $display("FAIL wb_acks got %b want 1111", {a0, a1, a2, a3}); end
        n_cmp++; if (wr_log.size() !== 2) begin n_bad++; $display("FAIL wb_wr_count got %0d want 2", wr_log.size()); end
        else begin
            n_cmp++; if (wr_log[0] !== 16'h10AA) begin n_bad++; $display("FAIL wb_wr0 got %h want 10aa", wr_log[0]); end
            n_cmp++; if (wr_log[1] !== 16'h1155) begin n_bad++; $display("FAIL wb_wr1 got %h want 1155", wr_log[1]); end
        end
        n_cmp++; if (adr !== 8'h12) begin n_bad++; $display("FAIL wb_ptr got %h want 12", adr); end
        n_cmp++; if (busy !== 1'b0 || sda_oen !== 1'b1) begin n_bad++; $display("FAIL wb_stop got busy=%b oen=%b want 0 1", busy, sda_oen); end
        n_cmp++; if (rd_log.size() !== 0) begin n_bad++; $display("FAIL wb_no_rd got %0d want 0", rd_log.size()); end
    endtask

    task automatic test_reset_mid();
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h84 >> i));
        sda_c = 1'b1; #Q;
        scl = 1'b1;   #Q;
        n_cmp++; if (sda_oen !== 1'b0) begin n_bad++; $display("FAIL rm_ack_driven got %b want 0", sda_oen); end
        @(posedge clk);
        #3 n_reset = 1'b0;
        #1;
        n_cmp++; if (sda_oen !== 1'b1) begin n_bad++; $display("FAIL rm_async_release got %b want 1", sda_oen); end
        n_cmp++; if (adr !== 8'h00 || dat_o !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_outputs got adr=%h dat=%h busy=%b want 00 00 0", adr, dat_o, busy); end
        scl = 1'b1; sda_c = 1'b1;
        #100;
        n_reset = 1'b1;
        #200;
    endtask

    task automatic test_read_burst();
        logic a0, a1, a2;
        logic [7:0] b0, b1;
        clear_logs();
        rd_mem[8'h20] = 8'h3C;
        rd_mem[8'h21] = 8'hC3;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h20, a1);
        i2c_start();
        write_byte(8'h85, a2);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        #Q;
        n_cmp++; if (sda_oen !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rb_after_nack got oen=%b busy=%b want 1 0", sda_oen, busy); end
        i2c_stop();
        #200;
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_bad++; $display("FAIL rb_acks got %b want 111", {a0, a1, a2}); end
        n_cmp++; if (b0 !== 8'h3C) begin n_bad++; $display("FAIL rb_byte0 got %h want 3c", b0); end
        n_cmp++; if (b1 !== 8'hC3) begin n_bad++; $display("FAIL rb_byte1 got %h want c3", b1); end
        n_cmp++; if (rd_log.size() !== 2) begin n_bad++; $display("FAIL rb_rd_count got %0d want 2", rd_log.size()); end
        else begin
            n_cmp++; if (rd_log[0] !== 8'h20 || rd_log[1] !== 8'h21) begin n_bad++; $display("FAIL rb_rd_addr got %h %h want 20 21", rd_log[0], rd_log[1]); end
        end
        n_cmp++; if (wr_log.size() !== 0) begin n_bad++; $display("FAIL rb_no_wr got %0d want 0", wr_log.size()); end
        n_cmp++; if (adr !== 8'h22) begin n_bad++; $display("FAIL rb_ptr got %h want 22", adr); end
    endtask

    task automatic test_mismatch();
        logic a0, a1, a2;
        clear_logs();
        i2c_start();
        write_byte(8'h86, a0);
        write_byte(8'h12, a1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mm_busy got %b want 0", busy); end
        i2c_stop();
        i2c_start();
        write_byte(8'h00, a2);
        i2c_stop();
        #200;
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL mm_acks got %b want 000", {a0, a1, a2}); end
        n_cmp++; if (wr_log.size() + rd_log.size() !== 0) begin n_bad++; $display("FAIL mm_strobes got %0d want 0", wr_log.size() + rd_log.size()); end
        n_cmp++; if (adr !== 8'h22) begin n_bad++; $display("FAIL mm_ptr got %h want 22", adr); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        clear_logs();
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        #200;
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_bad++; $display("FAIL wr_acks got %b want 1111", {a0, a1, a2, a3}); end
        n_cmp++; if (wr_log.size() !== 2) begin n_bad++; $display("FAIL wrap_count got %0d want 2", wr_log.size()); end
        else begin
            n_cmp++; if (wr_log[0] !== 16'hFF11) begin n_bad++; $display("FAIL wrap_wr0 got %h want ff11", wr_log[0]); end
            n_cmp++; if (wr_log[1] !== 16'h0022) begin n_bad++; $display("FAIL wrap_wr1 got %h want 0022", wr_log[1]); end
        end
        n_cmp++; if (adr !== 8'h01) begin n_bad++; $display("FAIL wrap_ptr got %h want 01", adr); end
    endtask

    task automatic test_abort();
        logic a0, a1, a2, a3, a4, a5;
        clear_logs();
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h30, a1);
        for (int i = 7; i >= 4; i--) write_bit(1'(8'hA5 >> i));
        i2c_start();
        n_cmp++; if (wr_log.size() !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL ab_after_start got wr=%0d busy=%b want 0 0", wr_log.size(), busy); end
        write_byte(8'h84, a2);
        write_byte(8'h40, a3);
        write_byte(8'h99, a4);
        i2c_stop();
        #200;
        n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin n_bad++; $display("FAIL ab_acks got %b want 11111", {a0, a1, a2, a3, a4}); end
        n_cmp++; if (wr_log.size() !== 1) begin n_bad++; $display("FAIL ab_count got %0d want 1", wr_log.size()); end
        else begin
            n_cmp++; if (wr_log[0] !== 16'h4099) begin n_bad++; $display("FAIL ab_wr got %h want 4099", wr_log[0]); end
        end
        clear_logs();
        i2c_start();
        write_byte(8'h84, a5);
        i2c_stop();
        #200;
        n_cmp++; if (a5 !== 1'b1) begin n_bad++; $display("FAIL aw_stop_ack got %b want 1", a5); end
        n_cmp++; if (wr_log.size() + rd_log.size() !== 0) begin n_bad++; $display("FAIL aw_stop_strobes got %0d want 0", wr_log.size() + rd_log.size()); end
        n_cmp++; if (adr !== 8'h41) begin n_bad++; $display("FAIL aw_stop_ptr got %h want 41", adr); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
        test_reset();
        test_write_burst();
        test_reset_mid();
        test_read_burst();
        test_mismatch();
        test_wrap();
        test_abort();
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL strobe_overlap got %0d want 0", overlap); end
        n_cmp++; if (wide !== 0) begin n_bad++; $display("FAIL strobe_width got %0d want 0", wide); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
